// File: rtl/rx_cnt_pkg.sv
// rx_cnt_pkg: shared definitions for the rx_word_counter slice.
//   rx_state_e      - FSM state encoding (IDLE, COUNT, DONE, OVFL)
//   DefaultBitW     - default bits per word
//   DefaultMaxWords - default maximum words per packet
package rx_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE,
        OVFL
    } rx_state_e;

    localparam int unsigned DefaultBitW     = 8;
    localparam int unsigned DefaultMaxWords = 64;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: loadable-limit up counter with synchronous clear.
// Counts 0 .. rollover_val-1 and wraps to 0 on the increment that would
// reach rollover_val.
//   clk          - system clock, rising edge
//   n_rst        - asynchronous active-low reset
//   clear        - synchronous clear, wins over count_enable
//   count_enable - increment this cycle
//   rollover_val - modulus of the count
//   count_out    - registered count value
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_inc;
    logic [NUM_CNT_BITS-1:0] count_d;

    assign count_inc = count_out + NUM_CNT_BITS'(1);

    always_comb begin
        count_d = count_out;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_inc == rollover_val) ? '0 : count_inc;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else begin
            count_out <= count_d;
        end
    end

endmodule

// File: rtl/rx_word_counter.sv
// rx_word_counter: counts sampled bits into words and words into packets.
//   clk        - system clock, rising edge
//   n_rst      - asynchronous active-low reset
//   cnt_up     - one-cycle strobe for a sampled bit
//   pause      - marks the strobed bit as stuffed (not counted)
//   clear      - synchronous restart to IDLE, highest priority
//   eop        - end of packet
//   bit_count  - bits received in the current word
//   word_count - complete words received in the packet (saturates at MAX_WORDS)
//   word_done  - one-cycle pulse per completed word
//   pkt_done   - one-cycle pulse when eop closes a packet
//   align_err  - level: packet closed with a partial word
//   overflow   - level: more than MAX_WORDS words arrived
module rx_word_counter
    import rx_cnt_pkg::*;
#(
    parameter int unsigned BIT_W     = DefaultBitW,
    parameter int unsigned MAX_WORDS = DefaultMaxWords,
    localparam int unsigned BCW      = $clog2(BIT_W + 1),
    localparam int unsigned WCW      = $clog2(MAX_WORDS + 1)
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           cnt_up,
    input  logic           pause,
    input  logic           clear,
    input  logic           eop,
    output logic [BCW-1:0] bit_count,
    output logic [WCW-1:0] word_count,
    output logic           word_done,
    output logic           pkt_done,
    output logic           align_err,
    output logic           overflow
);

    rx_state_e      state_q;
    logic           valid_bit;
    logic           last_bit;
    logic           at_max;
    logic [BCW-1:0] bit_next;

    // Bits are only accepted while a packet can still grow.
    assign valid_bit = cnt_up & ~pause & ((state_q == IDLE) | (state_q == COUNT));
    assign last_bit  = (bit_count == BCW'(BIT_W - 1));
    assign at_max    = (word_count == WCW'(MAX_WORDS));

    // Post-update bit count, so eop alongside a bit judges alignment after counting it.
    assign bit_next  = valid_bit ? (last_bit ? '0 : bit_count + BCW'(1)) : bit_count;

    flex_counter #(
        .NUM_CNT_BITS (BCW)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (valid_bit),
        .rollover_val (BCW'(BIT_W)),
        .count_out    (bit_count)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            word_count <= '0;
            word_done  <= 1'b0;
            pkt_done   <= 1'b0;
            align_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            word_done <= 1'b0;
            pkt_done  <= 1'b0;
            if (clear) begin
                state_q    <= IDLE;
                word_count <= '0;
                align_err  <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, COUNT: begin
                        if (valid_bit) begin
                            state_q <= COUNT;
                            if (last_bit) begin
                                if (at_max) begin
                                    // Saturate: no wrap and no word_done for the extra word.
                                    state_q  <= OVFL;
                                    overflow <= 1'b1;
                                end else begin
                                    word_count <= word_count + WCW'(1);
                                    word_done  <= 1'b1;
                                end
                            end
                        end
                        // eop in IDLE is ignored; later assignment overrides OVFL/COUNT.
                        if ((state_q == COUNT) && eop) begin
                            state_q   <= DONE;
                            pkt_done  <= 1'b1;
                            align_err <= (bit_next != '0);
                        end
                    end
                    OVFL: begin
                        if (eop) begin
                            state_q  <= DONE;
                            pkt_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
